// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin arbiter between the CPU memory micro-op
// port (A) and the debug/loader port (B) for a single banked data memory.
// Sequences bank-select, address, access and completion one transaction at a
// time, and skips the bank-select write when the cached bank already matches.
module data_memory_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int BANK_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [BANK_W-1:0] a_bank,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [BANK_W-1:0] b_bank,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [BANK_W-1:0] mem_bank,
    output logic              mem_bank_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_addr_wr_en,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [2:0] {
        S_IDLE, S_BANK, S_ADDR, S_ACCESS, S_WAIT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic [BANK_W-1:0] bank_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              owner_q;
    logic              last_owner_q;
    logic [BANK_W-1:0] cur_bank_q;
    logic              bank_valid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    // Arbitration: a lone requester wins; on a tie the port that did not go
    // last wins, so each port waits at most one foreign transaction.
    logic              grant_b;
    logic              any_req;
    logic [BANK_W-1:0] sel_bank;

    assign any_req  = a_req | b_req;
    assign grant_b  = b_req & (~a_req | ~last_owner_q);
    assign sel_bank = grant_b ? b_bank : a_bank;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; bank step is skipped when the cached bank matches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    if (!bank_valid_q || (sel_bank != cur_bank_q)) state_d = S_BANK;
                    else                                           state_d = S_ADDR;
                end
            end
            S_BANK:   state_d = S_ADDR;
            S_ADDR:   state_d = S_ACCESS;
            S_ACCESS: state_d = we_q ? S_DONE : S_WAIT;
            S_WAIT:   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Transaction latch, bank cache and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            bank_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cur_bank_q   <= '0;
            bank_valid_q <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            if (state_q == S_IDLE && any_req) begin
                we_q         <= grant_b ? b_we    : a_we;
                bank_q       <= sel_bank;
                addr_q       <= grant_b ? b_addr  : a_addr;
                wdata_q      <= grant_b ? b_wdata : a_wdata;
                owner_q      <= grant_b;
                last_owner_q <= grant_b;
            end
            if (state_q == S_BANK) begin
                cur_bank_q   <= bank_q;
                bank_valid_q <= 1'b1;
            end
            // Memory returns data the cycle after the read strobe.
            if (state_q == S_WAIT) begin
                if (owner_q) b_rdata_q <= mem_rdata;
                else         a_rdata_q <= mem_rdata;
            end
        end
    end

    // Outputs decoded from the state register only.
    assign mem_bank_wr_en = (state_q == S_BANK);
    assign mem_addr_wr_en = (state_q == S_ADDR);
    assign mem_wr_en      = (state_q == S_ACCESS) &  we_q;
    assign mem_rd_en      = (state_q == S_ACCESS) & ~we_q;
    assign a_ack          = (state_q == S_DONE) & ~owner_q;
    assign b_ack          = (state_q == S_DONE) &  owner_q;
    assign busy           = (state_q != S_IDLE);
    assign owner          = owner_q;
    assign mem_bank       = bank_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a small banked memory model.
module tb_data_memory_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [2:0] a_bank, b_bank;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_ack, b_ack;
    logic [7:0] a_rdata, b_rdata;
    logic [2:0] mem_bank;
    logic       mem_bank_wr_en, mem_addr_wr_en, mem_rd_en, mem_wr_en;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       busy, owner;

    always #5 clk = ~clk;

    data_memory_arbiter #(.DATA_W(8), .ADDR_W(8), .BANK_W(3)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_bank(a_bank), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_bank(b_bank), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_bank(mem_bank), .mem_bank_wr_en(mem_bank_wr_en),
        .mem_addr(mem_addr), .mem_addr_wr_en(mem_addr_wr_en),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    // Memory model: unwritten cells read as {bank,5'b0} ^ addr ^ 0xC3.
    bit [7:0] mem_m [8][256];
    bit       vld_m [8][256];
    bit [2:0] bank_r;
    bit [7:0] addr_r;
    always @(posedge clk) begin
        if (mem_bank_wr_en) bank_r <= mem_bank;
        if (mem_addr_wr_en) addr_r <= mem_addr;
        if (mem_wr_en) begin
            mem_m[bank_r][addr_r] <= mem_wdata;
            vld_m[bank_r][addr_r] <= 1'b1;
        end
        if (mem_rd_en)
            mem_rdata <= vld_m[bank_r][addr_r] ? mem_m[bank_r][addr_r]
                                               : ({bank_r, 5'b0} ^ addr_r ^ 8'hC3);
        else
            mem_rdata <= 8'h00;
    end

    int n_chk = 0, n_pass = 0;
    int cyc, bank_cyc, addr_cyc, rd_cyc, wr_cyc, a_ack_cyc, b_ack_cyc;
    int n_a_ack, n_b_ack, n_ovl, n_both;
    logic [2:0] bank_seen;
    logic [7:0] addr_seen, wd_seen;
    bit   busy_h [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clr();
        cyc = 0; bank_cyc = -1; addr_cyc = -1; rd_cyc = -1; wr_cyc = -1;
        a_ack_cyc = -1; b_ack_cyc = -1; n_a_ack = 0; n_b_ack = 0;
        n_ovl = 0; n_both = 0;
        for (int i = 0; i < 64; i++) busy_h[i] = 1'b1;
    endtask

    // Advance one cycle and record what the DUT did in it.
    task automatic step();
        int s;
        @(posedge clk); cyc++;
        @(negedge clk);
        s = int'(mem_bank_wr_en) + int'(mem_addr_wr_en) + int'(mem_rd_en) + int'(mem_wr_en);
        if (s > 1) n_ovl++;
        if (mem_bank_wr_en) begin bank_cyc = cyc; bank_seen = mem_bank; end
        if (mem_addr_wr_en) begin addr_cyc = cyc; addr_seen = mem_addr; end
        if (mem_wr_en)      begin wr_cyc = cyc; wd_seen = mem_wdata; end
        if (mem_rd_en)      rd_cyc = cyc;
        if (a_ack) begin n_a_ack++; a_ack_cyc = cyc; end
        if (b_ack) begin n_b_ack++; b_ack_cyc = cyc; end
        if (a_ack && b_ack) n_both++;
        if (cyc < 64) busy_h[cyc] = busy;
    endtask

    // Issue one request from IDLE; returns one cycle after the ack, in IDLE.
    task automatic run(input string tag, input bit p, input bit we, input logic [2:0] bank,
                       input logic [7:0] addr, input logic [7:0] wd);
        if (!p) begin a_we = we; a_bank = bank; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
        else    begin b_we = we; b_bank = bank; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
        clr();
        while ((p ? n_b_ack : n_a_ack) == 0 && cyc < 20) step();
        a_req = 1'b0; b_req = 1'b0;
        chk({tag, "_acked"}, 32'((p ? n_b_ack : n_a_ack) != 0), 32'd1);
        @(posedge clk); @(negedge clk);
    endtask

    int bad;

    initial begin
        rst = 1'b1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_bank = 0; b_bank = 0; a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   busy, 0);
        chk("rst_strobe", {mem_bank_wr_en, mem_addr_wr_en, mem_rd_en, mem_wr_en}, 0);
        chk("rst_ack",    {a_ack, b_ack}, 0);
        chk("rst_owner",  owner, 0);
        chk("rst_regs",   {mem_bank, mem_addr, mem_wdata, a_rdata, b_rdata}, 0);
        rst = 1'b0;

        // A write, bank miss after reset.
        run("aw0", 0, 1, 3'd0, 8'h10, 8'h5A);
        chk("aw0_bank_cyc", bank_cyc, 1);   chk("aw0_bank", bank_seen, 0);
        chk("aw0_addr_cyc", addr_cyc, 2);   chk("aw0_addr", addr_seen, 8'h10);
        chk("aw0_wr_cyc",   wr_cyc, 3);     chk("aw0_wdata", wd_seen, 8'h5A);
        chk("aw0_ack_cyc",  a_ack_cyc, 4);  chk("aw0_no_back", n_b_ack, 0);

        // A write, bank hit.
        run("aw1", 0, 1, 3'd0, 8'h20, 8'h33);
        chk("aw1_no_bank", bank_cyc, -1);   chk("aw1_ack_cyc", a_ack_cyc, 3);

        // A read, bank hit.
        run("ar0", 0, 0, 3'd0, 8'h10, 8'h00);
        chk("ar0_no_bank", bank_cyc, -1);   chk("ar0_rd_cyc", rd_cyc, 2);
        chk("ar0_ack_cyc", a_ack_cyc, 4);   chk("ar0_rdata", a_rdata, 8'h5A);
        repeat (3) @(negedge clk);
        chk("ar0_rdata_held", a_rdata, 8'h5A);

        // Tie with last_owner = A: B (bank 2 read, miss) first, then A.
        b_we = 0; b_bank = 3'd2; b_addr = 8'h07; b_wdata = 0; b_req = 1'b1;
        a_we = 0; a_bank = 3'd0; a_addr = 8'h20; a_wdata = 0; a_req = 1'b1;
        clr();
        while (n_a_ack == 0 && cyc < 30) begin
            step();
            if (b_ack) b_req = 1'b0;
        end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("tie_b_ack_cyc", b_ack_cyc, 5);  chk("tie_a_ack_cyc", a_ack_cyc, 11);
        chk("tie_gap_idle", busy_h[6], 0);   chk("tie_bank_b", bank_seen, 0);
        chk("tie_ack_count", {n_a_ack[7:0], n_b_ack[7:0]}, 16'h0101);
        chk("tie_overlap", n_ovl, 0);        chk("tie_both_ack", n_both, 0);
        chk("tie_b_rdata", b_rdata, 8'h84);  chk("tie_a_rdata", a_rdata, 8'h33);

        // B write bank 2 (miss after A used bank 0), then B read bank 2 (hit).
        run("bw", 1, 1, 3'd2, 8'h08, 8'h9C);
        chk("bw_bank_cyc", bank_cyc, 1);  chk("bw_bank", bank_seen, 3'd2);
        chk("bw_ack_cyc",  b_ack_cyc, 4); chk("bw_no_aack", n_a_ack, 0);
        run("br", 1, 0, 3'd2, 8'h08, 8'h00);
        chk("br_no_bank", bank_cyc, -1);  chk("br_ack_cyc", b_ack_cyc, 4);
        chk("br_rdata", b_rdata, 8'h9C);  chk("br_a_rdata_kept", a_rdata, 8'h33);

        // Reset during ACCESS of an A read.
        a_we = 0; a_bank = 3'd2; a_addr = 8'h08; a_req = 1'b1;
        clr();
        step(); chk("rr_addr_stage", mem_addr_wr_en, 1);
        step(); chk("rr_access", mem_rd_en, 1);
        rst = 1'b1; a_req = 1'b0;
        step();
        chk("rr_strobes", {mem_bank_wr_en, mem_addr_wr_en, mem_rd_en, mem_wr_en}, 0);
        chk("rr_acks", {a_ack, b_ack}, 0);
        chk("rr_busy", busy, 0);
        rst = 1'b0;
        repeat (5) step();
        chk("rr_no_ack", n_a_ack + n_b_ack, 0);
        run("rr_reissue", 0, 0, 3'd2, 8'h08, 8'h00);
        chk("rr_bank_cyc", bank_cyc, 1);  chk("rr_bank", bank_seen, 3'd2);
        chk("rr_ack_cyc", a_ack_cyc, 5);  chk("rr_rdata", a_rdata, 8'h9C);

        // Idle for 20 cycles.
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || mem_bank_wr_en || mem_addr_wr_en || mem_rd_en || mem_wr_en
                || a_ack || b_ack) bad++;
        end
        chk("idle_quiet", bad, 0);
        chk("idle_rdata", {a_rdata, b_rdata}, 16'h9C00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
